// File: rtl/arith_pipe_unit_if.sv
// Request/result handshake bundle for arith_pipe_unit.
// master = producer/consumer side, slave = the arithmetic unit.
interface arith_pipe_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_result;
  logic             out_overflow;
  logic [15:0]      out_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_count
  );
endinterface

// File: rtl/arith_pipe_unit.sv
// Pipelined unsigned ADD/SUB/AND/OR unit with valid/ready backpressure
// and a 16-bit completed-transfer counter.
module arith_pipe_unit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  arith_pipe_unit_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  logic             adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH:0]   res_d;
  logic             ovf_d;
  logic [WIDTH:0]   res_q [LATENCY];
  logic             ovf_q [LATENCY];
  logic             vld_q [LATENCY];
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             xfer;

  // The whole pipe moves as one shift register; a stalled output freezes
  // every stage, bubbles included.
  assign adv          = !vld_q[LATENCY-1] || bus.out_ready;
  assign bus.in_ready = adv && !rst;

  assign bus.out_valid    = vld_q[LATENCY-1];
  assign bus.out_result   = res_q[LATENCY-1];
  assign bus.out_overflow = ovf_q[LATENCY-1];
  assign bus.out_count    = cnt_q;

  assign xfer  = vld_q[LATENCY-1] && bus.out_ready;
  assign cnt_d = cnt_q + {15'd0, xfer};

  assign sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign dif = {1'b0, bus.in_a} - {1'b0, bus.in_b};

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        ovf_d = sum[WIDTH];
        res_d = (SATURATE != 0 && ovf_d) ? {1'b0, {WIDTH{1'b1}}} : sum;
      end
      OP_SUB: begin
        ovf_d = bus.in_a < bus.in_b;
        res_d = (SATURATE != 0 && ovf_d) ? '0 : dif;
      end
      OP_AND:  res_d = {1'b0, bus.in_a & bus.in_b};
      default: res_d = {1'b0, bus.in_a | bus.in_b};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      if (adv) begin
        vld_q[0] <= bus.in_valid;
        res_q[0] <= res_d;
        ovf_q[0] <= ovf_d;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          res_q[i] <= res_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
